// File: rtl/kernel_vec_pipe_pkg.sv
// Shared definitions for the vectorised two-stage streaming kernel.
// Latency: n/a (types, constants and helpers only).
// Backpressure: n/a.
package kernel_vec_pipe_pkg;

  // Operator encodings for the per-lane ALUs
  localparam int OP_ADD = 0;
  localparam int OP_SUB = 1;
  localparam int OP_MUL = 2;

  // Occupancy counter width for the default FIFO depth
  localparam int DEF_FIFO_DEPTH = 4;
  localparam int CNTW           = $clog2(DEF_FIFO_DEPTH) + 1;

  // Low bit of lane 'lane' inside a packed vector of 'width'-bit elements
  function automatic int lane_lsb(input int lane, input int width);
    return lane * width;
  endfunction

  // Occupancy counter width for an arbitrary FIFO depth (must reach DEPTH)
  function automatic int cnt_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/kernel_vec_stage.sv
// One registered valid/ready stage with LANES parallel ALUs (a OP b, or a OP a when SELF=1).
// Latency: 1 cycle from acceptance to out_vld.
// Backpressure: in_rdy = !vq | out_rdy, so a full stage accepts only when its data moves on.
module kernel_vec_stage
  import kernel_vec_pipe_pkg::*;
#(
  parameter int STREAMW = 32,
  parameter int LANES   = 2,
  parameter int OP      = OP_ADD,
  parameter int SELF    = 0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_vld,
  output logic                       in_rdy,
  input  logic [LANES*STREAMW-1:0]   in_a_dat,
  input  logic [LANES*STREAMW-1:0]   in_b_dat,
  output logic                       out_vld,
  input  logic                       out_rdy,
  output logic [LANES*STREAMW-1:0]   out_dat
);

  logic                     vq;
  logic [LANES*STREAMW-1:0] dq;
  logic [LANES*STREAMW-1:0] alu_dat;

  assign in_rdy  = !vq | out_rdy;
  assign out_vld = vq;
  assign out_dat = dq;

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    logic [STREAMW-1:0] a;
    logic [STREAMW-1:0] b;
    logic [STREAMW-1:0] r;

    assign a = in_a_dat[lane_lsb(i, STREAMW) +: STREAMW];
    // Self mode squares/doubles operand A; B is ignored
    assign b = (SELF != 0) ? a : in_b_dat[lane_lsb(i, STREAMW) +: STREAMW];

    // Lane ALU: results wrap modulo 2^STREAMW, mul keeps the low half
    always_comb begin
      r = a + b;
      case (OP)
        OP_SUB:  r = a - b;
        OP_MUL:  r = a * b;
        default: r = a + b;
      endcase
    end

    assign alu_dat[lane_lsb(i, STREAMW) +: STREAMW] = r;
  end

  // Load on handshake; drop valid once the held data has been taken downstream
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vq <= 1'b0;
      dq <= '0;
    end else begin
      if (in_vld && in_rdy) begin
        vq <= 1'b1;
        dq <= alu_dat;
      end else if (out_rdy) begin
        vq <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/kernel_vec_pipe.sv
// Vector kernel: per lane vout = (vin0 OP1 vin1) OP2 (same), two stages plus FWFT output FIFO.
// Latency: accepted at edge k, ovalid high from edge k+2 (visible 3 edges after acceptance).
// Backpressure: FIFO full stalls S2, then S1, then iready; oready never reaches iready combinationally.
module kernel_vec_pipe
  import kernel_vec_pipe_pkg::*;
#(
  parameter int STREAMW    = 32,
  parameter int LANES      = 2,
  parameter int OP1        = OP_ADD,
  parameter int OP2        = OP_MUL,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        ivalid,
  output logic                        iready,
  input  logic [LANES*STREAMW-1:0]    vin0,
  input  logic [LANES*STREAMW-1:0]    vin1,
  output logic                        ovalid,
  input  logic                        oready,
  output logic [LANES*STREAMW-1:0]    vout,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count
);

  localparam int VW  = LANES * STREAMW;
  localparam int PW  = $clog2(FIFO_DEPTH);
  localparam int FCW = cnt_width(FIFO_DEPTH);

  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("kernel_vec_pipe: FIFO_DEPTH must be a power of two and at least 2");
  end
  if (LANES < 1) begin : g_bad_lanes
    $error("kernel_vec_pipe: LANES must be at least 1");
  end

  logic          live_q;
  logic          s1_rdy;
  logic          s1_vld;
  logic [VW-1:0] s1_dat;
  logic          s2_rdy;
  logic          s2_vld;
  logic [VW-1:0] s2_dat;

  logic [VW-1:0]  mem [FIFO_DEPTH];
  logic [PW-1:0]  wr_ptr;
  logic [PW-1:0]  rd_ptr;
  logic [FCW-1:0] count_q;
  logic           fifo_full;
  logic           fifo_wr;
  logic           fifo_rd;

  // Hold iready low until the first edge after reset release
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) live_q <= 1'b0;
    else      live_q <= 1'b1;
  end

  assign iready = live_q & s1_rdy;

  kernel_vec_stage #(
    .STREAMW(STREAMW), .LANES(LANES), .OP(OP1), .SELF(0)
  ) u_s1 (
    .clk      (clk),
    .rst      (rst),
    .in_vld   (ivalid & live_q),
    .in_rdy   (s1_rdy),
    .in_a_dat (vin0),
    .in_b_dat (vin1),
    .out_vld  (s1_vld),
    .out_rdy  (s2_rdy),
    .out_dat  (s1_dat)
  );

  kernel_vec_stage #(
    .STREAMW(STREAMW), .LANES(LANES), .OP(OP2), .SELF(1)
  ) u_s2 (
    .clk      (clk),
    .rst      (rst),
    .in_vld   (s1_vld),
    .in_rdy   (s2_rdy),
    .in_a_dat (s1_dat),
    .in_b_dat (s1_dat),
    .out_vld  (s2_vld),
    .out_rdy  (!fifo_full),
    .out_dat  (s2_dat)
  );

  // Full is taken from the registered count, so a same-cycle read never frees a slot
  assign fifo_full  = (count_q == FCW'(FIFO_DEPTH));
  assign fifo_wr    = s2_vld & ~fifo_full;
  assign fifo_rd    = ovalid & oready;
  assign ovalid     = (count_q != '0);
  // Gate the head so vout reads zero whenever the FIFO is empty (including reset)
  assign vout       = ovalid ? mem[rd_ptr] : '0;
  assign fifo_count = count_q;

  // FIFO storage; contents are don't-care until covered by count_q
  always_ff @(posedge clk) begin
    if (fifo_wr) mem[wr_ptr] <= s2_dat;
  end

  // Pointers wrap naturally; occupancy tracks write minus read
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (fifo_wr) wr_ptr <= wr_ptr + PW'(1);
      if (fifo_rd) rd_ptr <= rd_ptr + PW'(1);
      count_q <= count_q + FCW'(fifo_wr) - FCW'(fifo_rd);
    end
  end

endmodule

// File: tb/tb_kernel_vec_pipe.sv
module tb_kernel_vec_pipe;

  localparam int SW    = 32;
  localparam int LANES = 2;
  localparam int OP1   = 0;
  localparam int OP2   = 2;
  localparam int FD    = 4;
  localparam int VW    = SW * LANES;
  localparam int CW    = $clog2(FD) + 1;

  logic          clk    = 1'b0;
  logic          rst    = 1'b0;
  logic          ivalid = 1'b0;
  logic          oready = 1'b0;
  logic [VW-1:0] vin0   = '0;
  logic [VW-1:0] vin1   = '0;
  wire           iready;
  wire           ovalid;
  wire  [VW-1:0] vout;
  wire  [CW-1:0] fifo_count;

  always #5 clk = ~clk;

  kernel_vec_pipe #(
    .STREAMW(SW), .LANES(LANES), .OP1(OP1), .OP2(OP2), .FIFO_DEPTH(FD)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .ivalid     (ivalid),
    .iready     (iready),
    .vin0       (vin0),
    .vin1       (vin1),
    .ovalid     (ovalid),
    .oready     (oready),
    .vout       (vout),
    .fifo_count (fifo_count)
  );

  int            total = 0;
  int            bad   = 0;
  logic [VW-1:0] sb[$];
  int            nin = 0, nout = 0, ncyc = 0;
  int            first_out = -1, last_out = -1;
  int            iready_drops = 0;
  logic          hold_vld = 1'b0;
  logic [VW-1:0] hold_dat = '0;
  int            base_in, base_out;

  task automatic chk(input string tag, input logic [VW-1:0] obs, input logic [VW-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [SW-1:0] opf(input int op, input logic [SW-1:0] x, input logic [SW-1:0] y);
    case (op)
      0:       return x + y;
      1:       return x - y;
      default: return x * y;
    endcase
  endfunction

  function automatic logic [VW-1:0] model(input logic [VW-1:0] a, input logic [VW-1:0] b);
    logic [SW-1:0] l1;
    model = '0;
    for (int i = 0; i < LANES; i++) begin
      l1 = opf(OP1, a[i*SW +: SW], b[i*SW +: SW]);
      model[i*SW +: SW] = opf(OP2, l1, l1);
    end
  endfunction

  function automatic logic [VW-1:0] rvec();
    rvec = '0;
    for (int i = 0; i < LANES; i++) rvec[i*SW +: SW] = SW'($urandom());
  endfunction

  // One clock: drive at negedge, sample #1 later, account for transfers at the next posedge
  task automatic cyc(input logic iv, input logic [VW-1:0] a, input logic [VW-1:0] b, input logic ordy);
    @(negedge clk);
    ivalid = iv; vin0 = a; vin1 = b; oready = ordy;
    #1;
    if (hold_vld) begin
      chk("stall_ovalid", VW'(ovalid), VW'(1));
      chk("stall_vout", vout, hold_dat);
    end
    if (ovalid && oready) begin
      chk("sb_nonempty", VW'(sb.size() != 0), VW'(1));
      if (sb.size() != 0) chk("vout", vout, sb.pop_front());
      nout++;
      if (first_out < 0) first_out = ncyc;
      last_out = ncyc;
    end
    if (iv && !iready) iready_drops++;
    if (ivalid && iready) begin
      sb.push_back(model(a, b));
      nin++;
    end
    hold_vld = ovalid && !oready;
    hold_dat = vout;
    ncyc++;
  endtask

  // Single vector on an empty pipe with constant expectation and latency checks
  task automatic one_shot(input string tag, input logic [VW-1:0] a, input logic [VW-1:0] b,
                          input logic [VW-1:0] exp);
    @(negedge clk);
    ivalid = 1'b1; vin0 = a; vin1 = b; oready = 1'b0;
    #1 chk({tag, "_iready"}, VW'(iready), VW'(1));
    @(negedge clk);
    ivalid = 1'b0;
    #1 chk({tag, "_lat_k"}, VW'(ovalid), VW'(0));
    @(negedge clk);
    #1 chk({tag, "_lat_k1"}, VW'(ovalid), VW'(0));
    @(negedge clk);
    #1 chk({tag, "_lat_k2"}, VW'(ovalid), VW'(1));
    chk({tag, "_vout"}, vout, exp);
    chk({tag, "_count"}, VW'(fifo_count), VW'(1));
    oready = 1'b1;
    @(negedge clk);
    oready = 1'b0;
    #1 chk({tag, "_drained"}, VW'(ovalid), VW'(0));
    chk({tag, "_count0"}, VW'(fifo_count), VW'(0));
  endtask

  initial begin
    // Reset state
    #12;
    chk("rst_iready", VW'(iready), VW'(0));
    chk("rst_ovalid", VW'(ovalid), VW'(0));
    chk("rst_vout", vout, VW'(0));
    chk("rst_count", VW'(fifo_count), VW'(0));
    @(negedge clk);
    rst = 1'b1;
    #1 chk("rel_iready_pre_edge", VW'(iready), VW'(0));
    @(posedge clk);
    #1 chk("rel_iready_first_edge", VW'(iready), VW'(1));

    // Basic dataflow and wrap-around arithmetic
    one_shot("basic", {32'd10, 32'd3}, {32'd5, 32'd4}, {32'd225, 32'd49});
    one_shot("wrap", {32'h0000FFFF, 32'hFFFFFFFF}, {32'd1, 32'd1}, {32'd0, 32'd0});
    one_shot("mul_low", {32'd100, 32'hFFFFFFFE}, {32'd200, 32'd1}, {32'd90000, 32'd1});

    // Back-pressure: offer 10 with oready low
    base_in = nin; base_out = nout;
    for (int i = 0; i < 10; i++) cyc(1'b1, rvec(), rvec(), 1'b0);
    cyc(1'b0, '0, '0, 1'b0);
    chk("bp_accepted", VW'(nin - base_in), VW'(6));
    chk("bp_count", VW'(fifo_count), VW'(FD));
    chk("bp_iready", VW'(iready), VW'(0));
    for (int i = 0; i < 30 && sb.size() != 0; i++) cyc(1'b0, '0, '0, 1'b1);
    chk("bp_drained", VW'(sb.size()), VW'(0));
    chk("bp_emitted", VW'(nout - base_out), VW'(6));

    // Full throughput
    base_out = nout; first_out = -1; last_out = -1; iready_drops = 0;
    for (int i = 0; i < 100; i++) cyc(1'b1, rvec(), rvec(), 1'b1);
    for (int i = 0; i < 20 && sb.size() != 0; i++) cyc(1'b0, '0, '0, 1'b1);
    chk("tp_outputs", VW'(nout - base_out), VW'(100));
    chk("tp_consecutive", VW'(last_out - first_out + 1), VW'(100));
    chk("tp_iready_drops", VW'(iready_drops), VW'(0));

    // Random stalls on both sides
    base_in = nin;
    for (int c = 0; c < 60000 && (nin - base_in) < 10000; c++)
      cyc($urandom_range(0, 3) != 0, rvec(), rvec(), $urandom_range(0, 3) != 0);
    for (int i = 0; i < 40 && sb.size() != 0; i++) cyc(1'b0, '0, '0, 1'b1);
    chk("rnd_accepted", VW'(nin - base_in), VW'(10000));
    chk("rnd_drained", VW'(sb.size()), VW'(0));

    // Reset with 3 vectors in flight
    for (int i = 0; i < 3; i++) cyc(1'b1, rvec(), rvec(), 1'b0);
    @(negedge clk);
    ivalid = 1'b0;
    #1 chk("mid_pre_ovalid", VW'(ovalid), VW'(1));
    rst = 1'b0;
    #1;
    chk("mid_rst_ovalid", VW'(ovalid), VW'(0));
    chk("mid_rst_vout", vout, VW'(0));
    chk("mid_rst_count", VW'(fifo_count), VW'(0));
    chk("mid_rst_iready", VW'(iready), VW'(0));
    sb.delete();
    hold_vld = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    one_shot("post_rst", {32'd10, 32'd3}, {32'd5, 32'd4}, {32'd225, 32'd49});
    base_out = nout;
    for (int i = 0; i < 8; i++) cyc(1'b0, '0, '0, 1'b1);
    chk("post_rst_no_stale", VW'(nout - base_out), VW'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
